// File: rtl/icache_mem_responder_pkg.sv
// Package cache_defs: icache fill widths, derived constants and the
// state encoding shared by the icache_mem_responder files.
package cache_defs;

    localparam int ICACHE_ADDR_WIDTH     = 32;
    localparam int ICACHE_LINE_WIDTH     = 128;
    localparam int ICACHE_DATA_WIDTH     = 32;
    localparam int ICACHE_OFFSET_BITS    = $clog2(ICACHE_LINE_WIDTH / 8);
    localparam int ICACHE_BEATS          = ICACHE_LINE_WIDTH / ICACHE_DATA_WIDTH;
    localparam int ICACHE_TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        RESP,
        GAP
    } type_icache_mem_state_e;

endpackage

// File: rtl/icache_mem_responder_if.sv
// Line-fill request/response and word-wide memory bus of the responder.
// slave = responder side, master = icache controller plus memory side.
interface icache_mem_responder_if
    import cache_defs::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int LINE_WIDTH = ICACHE_LINE_WIDTH,
    parameter int WORD_WIDTH = ICACHE_DATA_WIDTH
);

    logic                  icache2mem_req_i;
    logic [ADDR_WIDTH-1:0] icache2mem_addr_i;
    logic                  icache_kill_i;
    logic                  mem2icache_ack_o;
    logic [LINE_WIDTH-1:0] mem2icache_data_o;
    logic                  mem2icache_err_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WORD_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    modport slave (
        input  icache2mem_req_i,
        input  icache2mem_addr_i,
        input  icache_kill_i,
        input  mem_rdata_i,
        input  mem_ack_i,
        output mem2icache_ack_o,
        output mem2icache_data_o,
        output mem2icache_err_o,
        output mem_req_o,
        output mem_addr_o
    );

    modport master (
        output icache2mem_req_i,
        output icache2mem_addr_i,
        output icache_kill_i,
        output mem_rdata_i,
        output mem_ack_i,
        input  mem2icache_ack_o,
        input  mem2icache_data_o,
        input  mem2icache_err_o,
        input  mem_req_o,
        input  mem_addr_o
    );

endinterface

// File: rtl/icache_mem_responder_line_assembler.sv
// icache_line_assembler: beat counter, slot write decode and line
// register that collects memory words into one cache line.
module icache_line_assembler
    import cache_defs::*;
#(
    parameter int LINE_WIDTH = ICACHE_LINE_WIDTH,
    parameter int WORD_WIDTH = ICACHE_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start,
    input  logic                  wr,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic                  last,
    output logic [LINE_WIDTH-1:0] line
);

    localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0]                beat_q;
    logic [BEATS-1:0][WORD_WIDTH-1:0] line_q;

    assign last = (beat_q == LAST_BEAT);
    assign line = line_q;

    // Beat index: restarts on a new fill, advances on each accepted word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else if (start) begin
            beat_q <= '0;
        end else if (wr) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    // Line register: the current beat's slot takes the word; clear zeroes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
        end else if (clear) begin
            line_q <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (wr && (beat_q == BEAT_W'(i))) begin
                    line_q[i] <= rdata;
                end
            end
        end
    end

endmodule

// File: rtl/icache_mem_responder.sv
// Icache line-fill responder: reads a line as word beats from memory.
// Optional per-beat watchdog enabled by ICACHE_MEM_TIMEOUT_EN.
module icache_mem_responder
    import cache_defs::*;
#(
    parameter int ADDR_WIDTH     = ICACHE_ADDR_WIDTH,
    parameter int LINE_WIDTH     = ICACHE_LINE_WIDTH,
    parameter int WORD_WIDTH     = ICACHE_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = ICACHE_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    icache_mem_responder_if.slave bus
);

    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES =
        ADDR_WIDTH'(WORD_WIDTH / 8);

    type_icache_mem_state_e state_q;

    logic                  req_q;
    logic                  ack_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] base;
    logic                  accept;
    logic                  beat_wr;
    logic                  last_beat;
    logic                  tmo_hit;
    logic                  clear_line;
    logic [LINE_WIDTH-1:0] line;
    logic                  unused_off;

    assign base = {bus.icache2mem_addr_i[ADDR_WIDTH-1:OFF_BITS],
                   {OFF_BITS{1'b0}}};
    assign unused_off = ^bus.icache2mem_addr_i[OFF_BITS-1:0];

    assign accept = (state_q == IDLE)
                  && bus.icache2mem_req_i
                  && !bus.icache_kill_i;

    assign beat_wr = (state_q == READ)
                   && bus.mem_ack_i
                   && !bus.icache_kill_i;

    assign clear_line = tmo_hit
                      && (state_q == READ)
                      && !bus.icache_kill_i;

    assign bus.mem_req_o         = req_q;
    assign bus.mem_addr_o        = addr_q;
    assign bus.mem2icache_ack_o  = ack_q;
    assign bus.mem2icache_data_o = line;

`ifdef ICACHE_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = req_q && !bus.mem_ack_i && (tmo_q == TMO_LAST);
    assign bus.mem2icache_err_o = err_q;

    // Watchdog: cycles the current word request has waited for its ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (!req_q || bus.mem_ack_i) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign bus.mem2icache_err_o = 1'b0;
`endif

    // Fill sequencer: IDLE -> READ -> RESP -> GAP, DRAIN after a kill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
`ifdef ICACHE_MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= READ;
                        req_q   <= 1'b1;
                        addr_q  <= base;
`ifdef ICACHE_MEM_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                READ: begin
                    if (bus.icache_kill_i) begin
                        if (bus.mem_ack_i) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (bus.mem_ack_i) begin
                        if (last_beat) begin
                            state_q <= RESP;
                            req_q   <= 1'b0;
                            ack_q   <= 1'b1;
                        end else begin
                            addr_q <= addr_q + WORD_BYTES;
                        end
                    end else if (tmo_hit) begin
                        state_q <= RESP;
                        req_q   <= 1'b0;
                        ack_q   <= 1'b1;
`ifdef ICACHE_MEM_TIMEOUT_EN
                        err_q   <= 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (bus.mem_ack_i || tmo_hit) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                RESP: begin
                    state_q <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    icache_line_assembler #(
        .LINE_WIDTH (LINE_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_asm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (accept),
        .wr     (beat_wr),
        .clear  (clear_line),
        .rdata  (bus.mem_rdata_i),
        .last   (last_beat),
        .line   (line)
    );

endmodule
